// File: rtl/da_out_stage.sv
// Output conditioning for the DA FIR accumulator: round, scale by 2^SHIFT, saturate to OUT_W,
// then buffer in a small FIFO with valid/ready toward the consumer and drop accounting on overflow.
module da_out_stage #(
   parameter int SHIFT = 16,
   parameter int OUT_W = 16,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      clear,
   input  logic signed [38:0]        ACC_IN,
   input  logic                      valid_in,
   output logic signed [OUT_W-1:0]   out_data,
   output logic                      out_sat,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      ovf,
   output logic [7:0]                drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic signed [39:0] RND     = 40'sd1 <<< (SHIFT - 1);
   localparam logic signed [39:0] SAT_MAX = (40'sd1 <<< (OUT_W - 1)) - 40'sd1;
   localparam logic signed [39:0] SAT_MIN = -(40'sd1 <<< (OUT_W - 1));

   logic signed [39:0]      acc_ext;
   logic signed [39:0]      acc_rnd;
   logic signed [39:0]      acc_shf;
   logic signed [OUT_W-1:0] smp_val;
   logic                    smp_sat;

   // Adding half an LSB before the floor shift rounds ties toward +infinity.
   assign acc_ext = {ACC_IN[38], ACC_IN};
   assign acc_rnd = acc_ext + RND;
   assign acc_shf = acc_rnd >>> SHIFT;

   always_comb begin
      smp_val = acc_shf[OUT_W-1:0];
      smp_sat = 1'b0;
      if (acc_shf > SAT_MAX) begin
         smp_val = SAT_MAX[OUT_W-1:0];
         smp_sat = 1'b1;
      end else if (acc_shf < SAT_MIN) begin
         smp_val = SAT_MIN[OUT_W-1:0];
         smp_sat = 1'b1;
      end
   end

   logic                    p_valid;
   logic signed [OUT_W-1:0] p_data;
   logic                    p_sat;

   logic [OUT_W:0]  mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [OUT_W:0]  head;
   logic            full;
   logic            pop;
   logic            push;
   logic            drop;

   assign full      = (level == LW'(DEPTH));
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign push      = p_valid & (~full | pop);
   assign drop      = p_valid & full & ~pop;

   assign head     = mem[rd_ptr];
   assign out_data = out_valid ? $signed(head[OUT_W-1:0]) : '0;
   assign out_sat  = out_valid ? head[OUT_W] : 1'b0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_valid <= 1'b0;
         p_data  <= '0;
         p_sat   <= 1'b0;
      end else if (clear) begin
         p_valid <= 1'b0;
      end else begin
         p_valid <= valid_in;
         if (valid_in) begin
            p_data <= smp_val;
            p_sat  <= smp_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // Storage is not reset; pointers and level alone define what is valid.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= {p_sat, p_data};
   end

endmodule

// File: tb/tb_da_out_stage.sv
// Self-checking bench for da_out_stage: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_da_out_stage;
   localparam int SHIFT = 16;
   localparam int OUT_W = 16;
   localparam int DEPTH = 4;

   logic                    clk = 1'b0;
   logic                    resetn;
   logic                    clear;
   logic signed [38:0]      acc;
   logic                    valid_in;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_sat;
   logic                    out_valid;
   logic                    out_ready;
   logic [$clog2(DEPTH):0]  level;
   logic                    ovf;
   logic [7:0]              drop_cnt;

   always #5 clk = ~clk;

   da_out_stage #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .clear(clear), .ACC_IN(acc), .valid_in(valid_in),
      .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .ovf(ovf), .drop_cnt(drop_cnt)
   );

   typedef struct {int data; bit sat;} samp_t;
   typedef struct {longint acc; int exp_data; bit exp_sat;} vec_t;

   int     checks = 0;
   int     failures = 0;
   longint cur_acc;
   samp_t  mq[$];
   samp_t  popped[$];
   bit     mp_v;
   samp_t  mp;
   int     movf;
   int     mdrop;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference conversion: floor((acc + d/2) / d) by plain integer arithmetic, then clamp.
   function automatic samp_t ref_conv(input longint a);
      samp_t  s;
      longint d, x, r, q, hi, lo;
      d  = longint'(1) <<< SHIFT;
      x  = a + d / 2;
      r  = x % d;
      if (r < 0) r = r + d;
      q  = (x - r) / d;
      hi = (longint'(1) <<< (OUT_W - 1)) - 1;
      lo = -(longint'(1) <<< (OUT_W - 1));
      s.sat = 1'b0;
      if (q > hi) begin q = hi; s.sat = 1'b1; end
      else if (q < lo) begin q = lo; s.sat = 1'b1; end
      s.data = int'(q);
      return s;
   endfunction

   task automatic model_reset();
      mq.delete();
      mp_v  = 1'b0;
      movf  = 0;
      mdrop = 0;
   endtask

   task automatic model_edge();
      bit do_pop;
      bit was_full;
      if (!resetn || clear) begin
         model_reset();
         return;
      end
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && out_ready;
      if (do_pop) void'(mq.pop_front());
      if (mp_v) begin
         if (!was_full || do_pop) mq.push_back(mp);
         else begin
            movf = 1;
            if (mdrop < 255) mdrop++;
         end
      end
      mp_v = valid_in;
      if (valid_in) mp = ref_conv(cur_acc);
   endtask

   task automatic compare_model();
      samp_t e;
      e.data = 0;
      e.sat  = 1'b0;
      if (mq.size() != 0) e = mq[0];
      chk("out_valid", out_valid, longint'(mq.size() != 0));
      chk("level", level, mq.size());
      chk("ovf", ovf, movf);
      chk("drop_cnt", drop_cnt, mdrop);
      chk("out_data", $signed(out_data), e.data);
      chk("out_sat", out_sat, e.sat);
   endtask

   task automatic cycle();
      samp_t s;
      if (out_valid && out_ready) begin
         s.data = int'($signed(out_data));
         s.sat  = out_sat;
         popped.push_back(s);
      end
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic drive(input longint a);
      cur_acc = a;
      acc     = cur_acc[38:0];
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   vec_t vecs[8];

   initial begin
      logic [63:0]        rnd64;
      logic signed [38:0] r39;
      int                 mode;

      resetn = 1'b0; clear = 1'b0; valid_in = 1'b0; out_ready = 1'b0;
      drive(0);
      model_reset();
      repeat (2) cycle();
      @(negedge clk) resetn = 1'b1;
      cycle();
      chk("reset_data", out_data, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_level", level, 0);

      vecs[0] = '{98304, 2, 1'b0};
      vecs[1] = '{-98304, -1, 1'b0};
      vecs[2] = '{32767, 0, 1'b0};
      vecs[3] = '{32768, 1, 1'b0};
      vecs[4] = '{(longint'(1) <<< 38) - 1, 32767, 1'b1};
      vecs[5] = '{-(longint'(1) <<< 38), -32768, 1'b1};
      vecs[6] = '{2147450879, 32767, 1'b0};
      vecs[7] = '{-32768, 0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].acc);
         valid_in = 1'b1; out_ready = 1'b0;
         cycle();
         valid_in = 1'b0;
         cycle();
         chk("vec_valid", out_valid, 1);
         chk("vec_data", $signed(out_data), vecs[i].exp_data);
         chk("vec_sat", out_sat, vecs[i].exp_sat);
         out_ready = 1'b1;
         cycle();
         out_ready = 1'b0;
      end

      // Overflow: six pulses into a stalled FIFO
      do_clear();
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(longint'(k + 1) * 65536 + 100);
         valid_in = 1'b1;
         cycle();
      end
      valid_in = 1'b0;
      cycle();
      chk("ovf_level", level, 4);
      chk("ovf_flag", ovf, 1);
      chk("ovf_drops", drop_cnt, 2);
      popped.delete();
      out_ready = 1'b1;
      repeat (5) cycle();
      out_ready = 1'b0;
      chk("ovf_count", popped.size(), 4);
      for (int j = 0; j < 4; j++)
         chk("ovf_order", (j < popped.size()) ? popped[j].data : -999, j + 1);

      // Full FIFO with simultaneous push and pop
      do_clear();
      popped.delete();
      out_ready = 1'b0;
      valid_in  = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         drive(longint'(k) <<< 16);
         cycle();
      end
      chk("full_fill", level, 4);
      out_ready = 1'b1;
      for (int k = 6; k <= 15; k++) begin
         drive(longint'(k) <<< 16);
         cycle();
         chk("full_level", level, 4);
      end
      valid_in = 1'b0;
      repeat (6) cycle();
      out_ready = 1'b0;
      chk("full_drops", drop_cnt, 0);
      chk("full_count", popped.size(), 15);
      for (int j = 0; j < 15; j++)
         chk("full_order", (j < popped.size()) ? popped[j].data : -999, j + 1);

      // clear beats a same-edge valid_in
      do_clear();
      out_ready = 1'b0;
      valid_in  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive(longint'(k + 1) <<< 16);
         cycle();
      end
      valid_in  = 1'b0;
      cycle();
      out_ready = 1'b1;
      repeat (2) cycle();
      out_ready = 1'b0;
      chk("clr_pre_level", level, 2);
      chk("clr_pre_ovf", ovf, 1);
      popped.delete();
      clear = 1'b1; valid_in = 1'b1;
      drive(longint'(77) <<< 16);
      cycle();
      clear = 1'b0; valid_in = 1'b0;
      chk("clr_level", level, 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_drops", drop_cnt, 0);
      out_ready = 1'b1;
      repeat (4) cycle();
      out_ready = 1'b0;
      chk("clr_no_output", popped.size(), 0);

      // Asynchronous reset with three entries buffered
      do_clear();
      valid_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(longint'(k + 5) <<< 16);
         cycle();
      end
      valid_in = 1'b0;
      cycle();
      chk("async_pre_level", level, 3);
      #2 resetn = 1'b0;
      #1;
      chk("async_level", level, 0);
      chk("async_valid", out_valid, 0);
      model_reset();
      @(negedge clk) resetn = 1'b1;
      cycle();

      // drop_cnt saturates at 255
      do_clear();
      out_ready = 1'b0;
      valid_in  = 1'b1;
      drive(1000);
      repeat (300) cycle();
      valid_in = 1'b0;
      cycle();
      chk("drop_sat", drop_cnt, 255);

      // Randomized traffic against the model
      do_clear();
      for (int n = 0; n < 3000; n++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: begin
               rnd64 = {$urandom, $urandom};
               r39   = rnd64[38:0];
               drive(longint'(r39));
            end
            1: drive(longint'($urandom_range(0, 200000)) - 100000);
            2: drive((longint'($urandom_range(0, 2000)) - 1000) * 65536 + 32767
                     + longint'($urandom_range(0, 2)));
            default: drive(longint'($signed($urandom)));
         endcase
         valid_in  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         clear     = ($urandom_range(0, 99) == 0);
         cycle();
      end
      clear = 1'b0; valid_in = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
